// File: rtl/quad_dec_pkg.sv
// Shared definitions for the quadrature decoder.
//   phase_t      : decoder phase; Pxy means the last accepted sample was {a,b}=xy
//   FILT_LEN_DEF : default stable-sample count for the optional glitch filter
//   phase_of     : maps a decoded {a,b} sample onto its phase
//   fwd_of       : forward neighbour of a phase (P00->P01->P11->P10->P00)
package quad_dec_pkg;

  typedef enum logic [2:0] {
    INIT,
    P00,
    P01,
    P11,
    P10
  } phase_t;

  localparam int FILT_LEN_DEF = 4;

  function automatic phase_t phase_of(input logic a, input logic b);
    case ({a, b})
      2'b00:   return P00;
      2'b01:   return P01;
      2'b11:   return P11;
      default: return P10;
    endcase
  endfunction

  function automatic phase_t fwd_of(input phase_t p);
    case (p)
      P00:     return P01;
      P01:     return P11;
      P11:     return P10;
      P10:     return P00;
      default: return INIT;
    endcase
  endfunction

endpackage

// File: rtl/quad_filt.sv
// One quadrature channel front end: two-flop synchronizer plus optional
// glitch filter (enabled by defining QUAD_DEC_FILTER_EN).
//   clk, rst : clock, synchronous active-high reset
//   d        : raw asynchronous channel input
//   q        : synchronized (and, if enabled, filtered) level
//   vld      : q holds a real input sample (not a reset value)
module quad_filt #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic vld
);

  localparam bit FILT_LEN_OK = (FILT_LEN >= 2) && (FILT_LEN <= 255);

  if (!FILT_LEN_OK) begin : g_bad_len
    $error("quad_filt: FILT_LEN out of range 2..255");
  end

  logic       s1;
  logic       s2;
  logic [1:0] fill;

  // fill tracks how many real samples have entered the synchronizer since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      fill <= '0;
    end else begin
      s1   <= d;
      s2   <= s1;
      fill <= {fill[0], 1'b1};
    end
  end

`ifdef QUAD_DEC_FILTER_EN
  logic       filt_q;
  logic       primed;
  logic [7:0] cnt;
  logic       flip;

  // The FILT_LEN-th consecutive differing sample is passed straight through,
  // so the decoder sees the new level in the same cycle it is accepted.
  assign flip = primed && (s2 != filt_q) && (cnt == 8'(FILT_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      primed <= 1'b0;
      cnt    <= '0;
    end else if (!primed) begin
      if (fill[1]) begin
        filt_q <= s2;
        primed <= 1'b1;
      end
    end else if (s2 == filt_q) begin
      cnt <= '0;
    end else if (flip) begin
      filt_q <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign q   = flip ? s2 : filt_q;
  assign vld = primed;
`else
  assign q   = s2;
  assign vld = fill[1];
`endif

endmodule

// File: rtl/quad_dec.sv
// Quadrature decoder with signed position accumulator.
//   clk, rst : clock, synchronous active-high reset
//   syn_clr  : synchronous clear of pos and err
//   a, b     : asynchronous quadrature channels
//   en       : one-cycle step pulse (counter enable)
//   up       : step direction, 1 = forward; meaningful while en=1
//   err      : sticky illegal double-bit transition flag
//   pos      : N-bit two's-complement position, wraps modulo 2^N
// Optional glitch filter on each channel: define QUAD_DEC_FILTER_EN.
module quad_dec
  import quad_dec_pkg::*;
#(
  parameter int N        = 4,
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         syn_clr,
  input  logic         a,
  input  logic         b,
  output logic         en,
  output logic         up,
  output logic         err,
  output logic [N-1:0] pos
);

  localparam logic [N-1:0] ONE = N'(1);

  logic   sa, sb, va, vb;
  phase_t state_q, state_d, smp;
  logic   step, dir, bad;

  quad_filt #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk (clk),
    .rst (rst),
    .d   (a),
    .q   (sa),
    .vld (va)
  );

  quad_filt #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk (clk),
    .rst (rst),
    .d   (b),
    .q   (sb),
    .vld (vb)
  );

  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    dir     = 1'b0;
    bad     = 1'b0;
    smp     = phase_of(sa, sb);
    if (va && vb) begin
      if (state_q == INIT) begin
        state_d = smp;
      end else if (smp != state_q) begin
        state_d = smp;
        if (smp == fwd_of(state_q)) begin
          step = 1'b1;
          dir  = 1'b1;
        end else if (state_q == fwd_of(smp)) begin
          step = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      en      <= 1'b0;
      up      <= 1'b0;
      err     <= 1'b0;
      pos     <= '0;
    end else begin
      state_q <= state_d;
      en      <= step;
      if (step) up <= dir;
      if (syn_clr) begin
        pos <= '0;
        err <= 1'b0;
      end else begin
        if (step) pos <= dir ? pos + ONE : pos - ONE;
        if (bad)  err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_dec.sv
module tb_quad_dec;

  localparam int N        = 4;
  localparam int FILT_LEN = 4;
  localparam int MASK     = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         syn_clr = 1'b0;
  logic         a = 1'b0;
  logic         b = 1'b0;
  logic         en, up, err;
  logic [N-1:0] pos;

  int total = 0;
  int bad   = 0;

  quad_dec #(.N(N), .FILT_LEN(FILT_LEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .syn_clr (syn_clr),
    .a       (a),
    .b       (b),
    .en      (en),
    .up      (up),
    .err     (err),
    .pos     (pos)
  );

  always #5 clk = ~clk;

  // Reference model: position in the Gray cycle is 2*a + (a^b), so a forward
  // step is +1 mod 4, reverse is -1 mod 4 and a double-bit change is +2.
  int m_phase = -1;
  int m_en = 0, m_up = 0, m_err = 0, m_pos = 0;
  int hist[$];

  function automatic int gpos(input int ab);
    int ia, ib;
    ia = (ab >> 1) & 1;
    ib = ab & 1;
    return 2 * ia + (ia ^ ib);
  endfunction

  task automatic model_edge(input logic r, input logic c, input logic ia, input logic ib);
    int smp, d, g;
    if (r) begin
      m_phase = -1; m_en = 0; m_up = 0; m_err = 0; m_pos = 0;
      hist.delete();
    end else begin
      hist.push_back(2 * int'(ia) + int'(ib));
      m_en = 0;
      if (hist.size() == 3) begin
        smp = hist.pop_front();
        g = gpos(smp);
        if (m_phase < 0) begin
          m_phase = g;
        end else begin
          d = (g - m_phase + 4) % 4;
          if (d == 1) begin m_en = 1; m_up = 1; m_pos = (m_pos + 1) & MASK; end
          else if (d == 3) begin m_en = 1; m_up = 0; m_pos = (m_pos - 1) & MASK; end
          else if (d == 2) m_err = 1;
          m_phase = g;
        end
      end
      if (c) begin m_pos = 0; m_err = 0; end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic c, input logic ia, input logic ib);
    @(negedge clk);
    rst = r; syn_clr = c; a = ia; b = ib;
    @(posedge clk);
    model_edge(r, c, ia, ib);
    #1;
`ifndef QUAD_DEC_FILTER_EN
    chk("model", int'({en, up, err, pos}),
        (m_en << (N + 2)) | (m_up << (N + 1)) | (m_err << N) | m_pos);
`endif
  endtask

  typedef struct packed {
    logic       rst;
    logic       clr;
    logic       a;
    logic       b;
    logic       en;
    logic       up;
    logic       err;
    logic [3:0] pos;
  } vec_t;

  vec_t tbl [27];
  int   en_cnt, first_en;
  logic [1:0] fwd_seq [4];

  initial begin
`ifdef QUAD_DEC_FILTER_EN
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("flt_reset_state", int'({en, err, pos}), 0);
    // 3-cycle glitch on a must be swallowed
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("flt_glitch_en", int'(en), 0);
    end
    // level held: exactly one pulse FILT_LEN+1 edges after capture (P00->P10 = reverse)
    en_cnt = 0; first_en = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      if (en) begin
        en_cnt++;
        if (first_en < 0) first_en = i;
      end
    end
    chk("flt_pulse_count", en_cnt, 1);
    chk("flt_latency", first_en, FILT_LEN + 1);
    chk("flt_pos", int'(pos), MASK);
    chk("flt_up", int'(up), 0);
`else
    tbl = '{
      '{1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,4'h0},
      '{1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,4'h0},
      '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,4'h0},
      '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,4'h0},
      '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,4'h0},
      '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,4'h0},
      '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,4'h0},
      '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'h0},
      '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,4'h0},
      '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,4'h0},
      '{1'b0,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,4'h1},
      '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,4'h1},
      '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,4'h2},
      '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,4'h3},
      '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,4'h4},
      '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,4'h4},
      '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,4'h3},
      '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,4'h0},
      '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,4'h0},
      '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'h0},
      '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,4'h0},
      '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,4'h0},
      '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,4'h0},
      '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,4'h0},
      '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b1,4'h0},
      '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b1,4'h0},
      '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,4'h0}
    };
    for (int i = 0; i < 27; i++) begin
      cyc(tbl[i].rst, tbl[i].clr, tbl[i].a, tbl[i].b);
      chk($sformatf("tbl[%0d]", i), int'({en, up, err, pos}),
          int'({tbl[i].en, tbl[i].up, tbl[i].err, tbl[i].pos}));
    end

    // forward cycle, each level held 10 cycles; pulse exactly 2 edges after capture
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 10; i++) begin
        cyc(1'b0, 1'b0, fwd_seq[s][1], fwd_seq[s][0]);
        chk("fwd_en_timing", int'(en), (i == 2) ? 1 : 0);
        if (i == 2) chk("fwd_up", int'(up), 1);
      end
    end
    chk("fwd_pos4", int'(pos), 4);

    // clear, one reverse step to all-ones, then 16 forward steps wrap back
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr_pos", int'(pos), 0);
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rev_wrap_pos", int'(pos), MASK);
    chk("rev_up", int'(up), 0);
    for (int k = 0; k < 16; k++) begin
      repeat (3) cyc(1'b0, 1'b0, fwd_seq[(k + 3) % 4][1], fwd_seq[(k + 3) % 4][0]);
    end
    chk("fwd_wrap_pos", int'(pos), MASK);
    chk("wrap_no_err", int'(err), 0);

    // reset one edge after a capture cancels the pending pulse
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    en_cnt = 0;
    repeat (6) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (en) en_cnt++;
    end
    chk("rst_cancels_en", en_cnt, 0);
    chk("rst_pos", int'(pos), 0);

    // randomized traffic checked against the model every cycle
    for (int i = 0; i < 800; i++) begin
      logic r, c, na, nb;
      r  = ($urandom_range(0, 59) == 0);
      c  = ($urandom_range(0, 24) == 0);
      na = a; nb = b;
      if ($urandom_range(0, 3) == 0) begin
        na = 1'($urandom);
        nb = 1'($urandom);
      end
      cyc(r, c, na, nb);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_dec.md
QUAD_DEC -- requirements
Module: quad_dec

Interface
- REQ-001: Parameter N, default 4: width of the position register `pos`.
- REQ-002: Parameter FILT_LEN, default 4: stable-sample count for the glitch filter (range 2..255).
- REQ-003: clk  input  1  the single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- REQ-005: syn_clr  input  1  synchronous clear of `pos` and `err`.
- REQ-006: a, b  input  1 each  asynchronous quadrature channels.
- REQ-007: en  output  1  one-cycle step pulse; drives the `en` input of a universal binary counter directly.
- REQ-008: up  output  1  step direction, 1 = forward; valid only while en=1; drives the counter's `up` input.
- REQ-009: err  output  1  sticky flag for an illegal (double-bit) transition.
- REQ-010: pos  output  N  signed two's-complement position accumulator.

Function
- REQ-011: a and b each pass through a two-flop synchronizer; only the second-stage values (sa, sb) are decoded.
- REQ-012: The phase FSM has states INIT, P00, P01, P11, P10, where Pxy denotes {a,b}=xy.
- REQ-013: From INIT, the first decoded sample loads the matching Pxy state with no step and no error.
- REQ-014: Forward sequence is P00->P01->P11->P10->P00; a forward move sets en=1, up=1, pos=pos+1.
- REQ-015: A move to the reverse neighbour sets en=1, up=0, pos=pos-1.
- REQ-016: An unchanged sample holds the phase with en=0; up holds its last value.
- REQ-017: A change of both bits in one sample sets err=1, produces no step, and moves the FSM to the new Pxy state.
- REQ-018: en, up, err and pos are registered outputs.
- REQ-019: Latency without the filter: an a/b change captured at edge k produces en at edge k+2, high for exactly one cycle.
- REQ-020: pos wraps modulo 2^N: 0 minus 1 gives all-ones, and max plus 1 gives 0; wrap does not set err.
- REQ-021: While syn_clr=1, pos=0 and err=0 on the next edge, and any step in the same cycle is discarded from pos.
- REQ-022: syn_clr does not affect the FSM phase, en, or up.
- REQ-023: err stays set until syn_clr or rst; a new illegal transition in the same cycle as syn_clr leaves err=0.

Reset
- REQ-024: rst takes priority over all other inputs.
- REQ-025: On rst, synchronizer flops go to 0, FSM to INIT, and filter state to 0/idle.
- REQ-026: On rst, outputs go to en=0, up=0, err=0, pos=0.
- REQ-027: Reset asserted mid-step cancels any pending en pulse; the first post-reset sample is handled per REQ-013.

Configuration
- REQ-028: Macro QUAD_DEC_FILTER_EN is either defined or not defined.
- REQ-029: With QUAD_DEC_FILTER_EN defined, each synchronized channel passes through a glitch filter. The filtered value adopts the new level only after FILT_LEN consecutive samples differing from the current filtered value; any intervening match restarts the count.
- REQ-030: With the filter enabled, latency per REQ-019 becomes edge k+1+FILT_LEN.
- REQ-031: Without QUAD_DEC_FILTER_EN, the filter logic is absent and sa/sb feed the FSM directly; FILT_LEN is ignored.

Structure
- REQ-032: Package quad_dec_pkg holds the phase-state enum typedef and the FILT_LEN default constant.
- REQ-033: Sub-module quad_filt implements one channel's synchronizer plus optional filter and is instantiated twice, once for a and once for b.

Verification
- REQ-034: rst for 2 cycles with a=1, b=1, then release -> INIT loads P11; en=0, err=0, pos=0.
- REQ-035: From P00, drive {a,b}=01,11,10,00, each held for 10 cycles, filter off -> four en pulses with up=1; pos=4 (N=4); each pulse lands 2 edges after the change.
- REQ-036: From pos=0, one reverse step (00->10) -> en=1, up=0, pos=4'hF; then 16 forward steps -> pos=4'hF again (wrap).
- REQ-037: From P00, drive 00->11 -> err=1, no en, FSM=P11. Then syn_clr for 1 cycle -> err=0 and pos=0, with the phase kept at P11.
- REQ-038: Filter on, FILT_LEN=4: a glitch lasting 3 cycles -> no en. A level held for 6 cycles -> exactly one en, FILT_LEN+1 edges after capture.
- REQ-039: syn_clr coincident with a forward step -> pos=0, en=1, up=1 in the same cycle.
